// File: rtl/vga_box_painter.sv
// Paints a bouncing solid square over a background colour, two clock stages behind the sync generator.
// Optional VGA_BORDER_EN adds a white one-pixel frame around the active area.
module vga_box_painter #(
    parameter int          H_ACTIVE = 1024,
    parameter int          V_ACTIVE = 768,
    parameter int          BOX_SIZE = 64,
    parameter int          STEP     = 4,
    parameter logic [11:0] BG_RGB   = 12'h008,
    parameter logic [11:0] BOX_RGB  = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] h_count,
    input  logic [10:0] v_count,
    input  logic        ea,
    input  logic        h_synk,
    input  logic        v_synk,
    input  logic        move_en,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        h_synk_o,
    output logic        v_synk_o,
    output logic        de_o
);

    localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
`ifdef VGA_BORDER_EN
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
`endif

    logic [10:0] x_pos, y_pos, x_nxt, y_nxt;
    logic        x_neg, y_neg, x_neg_nxt, y_neg_nxt;
    logic        v_prev;
    logic        frame_tick;

    logic        s1_hit, s1_de, s1_hs, s1_vs;
`ifdef VGA_BORDER_EN
    logic        s1_edge;
`endif
    logic [11:0] pix_rgb;
    logic [11:0] rgb_q;
    logic        hs_q, vs_q, de_q;

    // v_prev follows v_synk even in reset, so a v_synk already low at release is not a tick.
    always_ff @(posedge clk) begin
        v_prev <= v_synk;
    end

    assign frame_tick = v_prev & ~v_synk;

    always_comb begin
        x_nxt     = x_pos;
        y_nxt     = y_pos;
        x_neg_nxt = x_neg;
        y_neg_nxt = y_neg;
        if (frame_tick && move_en) begin
            if (!x_neg) begin
                if (x_pos + STEP_W >= MAX_X) begin
                    x_nxt     = MAX_X;
                    x_neg_nxt = 1'b1;
                end else begin
                    x_nxt = x_pos + STEP_W;
                end
            end else begin
                if (x_pos <= STEP_W) begin
                    x_nxt     = '0;
                    x_neg_nxt = 1'b0;
                end else begin
                    x_nxt = x_pos - STEP_W;
                end
            end
            if (!y_neg) begin
                if (y_pos + STEP_W >= MAX_Y) begin
                    y_nxt     = MAX_Y;
                    y_neg_nxt = 1'b1;
                end else begin
                    y_nxt = y_pos + STEP_W;
                end
            end else begin
                if (y_pos <= STEP_W) begin
                    y_nxt     = '0;
                    y_neg_nxt = 1'b0;
                end else begin
                    y_nxt = y_pos - STEP_W;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_pos <= '0;
            y_pos <= '0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
        end else begin
            x_pos <= x_nxt;
            y_pos <= y_nxt;
            x_neg <= x_neg_nxt;
            y_neg <= y_neg_nxt;
        end
    end

    // Stage 1: register timing inputs and resolve the box hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit <= 1'b0;
            s1_de  <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
        end else begin
            s1_hit <= (h_count >= x_pos) && (h_count < x_pos + BOX_W) &&
                      (v_count >= y_pos) && (v_count < y_pos + BOX_W);
            s1_de  <= ea;
            s1_hs  <= h_synk;
            s1_vs  <= v_synk;
        end
    end

`ifdef VGA_BORDER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_edge <= 1'b0;
        end else begin
            s1_edge <= (h_count == 11'd0) || (h_count == H_LAST) ||
                       (v_count == 11'd0) || (v_count == V_LAST);
        end
    end
`endif

    always_comb begin
        pix_rgb = 12'h000;
        if (s1_de) begin
`ifdef VGA_BORDER_EN
            if (s1_edge) begin
                pix_rgb = 12'hFFF;
            end else if (s1_hit) begin
                pix_rgb = BOX_RGB;
            end else begin
                pix_rgb = BG_RGB;
            end
`else
            if (s1_hit) begin
                pix_rgb = BOX_RGB;
            end else begin
                pix_rgb = BG_RGB;
            end
`endif
        end
    end

    // Stage 2: colour and syncs leave together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= pix_rgb;
            hs_q  <= s1_hs;
            vs_q  <= s1_vs;
            de_q  <= s1_de;
        end
    end

    assign r        = rgb_q[11:8];
    assign g        = rgb_q[7:4];
    assign b        = rgb_q[3:0];
    assign h_synk_o = hs_q;
    assign v_synk_o = vs_q;
    assign de_o     = de_q;

endmodule

// File: tb/tb_vga_box_painter.sv
// Scoreboard bench for vga_box_painter: a default-size DUT plus a 130x130 DUT that reaches a corner bounce.
module tb_vga_box_painter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ea, ea_c, h_synk, v_synk, move_en;
    logic [10:0] h_count, v_count, h_count_c, v_count_c;
    logic [3:0]  r, g, b, rc, gc, bc;
    logic        hso, vso, deo, hsoc, vsoc, deoc;
    logic        rst_req, me_req;

    vga_box_painter dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .ea(ea),
        .h_synk(h_synk), .v_synk(v_synk), .move_en(move_en),
        .r(r), .g(g), .b(b), .h_synk_o(hso), .v_synk_o(vso), .de_o(deo)
    );

    vga_box_painter #(.H_ACTIVE(130), .V_ACTIVE(130)) u_corner (
        .clk(clk), .rst(rst), .h_count(h_count_c), .v_count(v_count_c), .ea(ea_c),
        .h_synk(h_synk), .v_synk(v_synk), .move_en(move_en),
        .r(rc), .g(gc), .b(bc), .h_synk_o(hsoc), .v_synk_o(vsoc), .de_o(deoc)
    );

`ifdef VGA_BORDER_EN
    localparam logic [11:0] EDGE_RGB = 12'hFFF;
`else
    localparam logic [11:0] EDGE_RGB = 12'h008;
`endif
    localparam logic [14:0] IDLE = {12'h000, 1'b1, 1'b1, 1'b0};

    typedef struct {
        logic [14:0] exp_m;
        logic [14:0] exp_c;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due != cyc) begin
                errors++;
                $display("FAIL %s: result presented at cycle %0d, required at cycle %0d", e.name, cyc, e.due);
            end else begin
                if ({r, g, b, hso, vso, deo} !== e.exp_m) begin
                    errors++;
                    $display("FAIL %s main: got rgb=%h hs=%b vs=%b de=%b, required rgb=%h hs=%b vs=%b de=%b",
                             e.name, {r, g, b}, hso, vso, deo,
                             e.exp_m[14:3], e.exp_m[2], e.exp_m[1], e.exp_m[0]);
                end
                checks++;
                if ({rc, gc, bc, hsoc, vsoc, deoc} !== e.exp_c) begin
                    errors++;
                    $display("FAIL %s corner: got rgb=%h hs=%b vs=%b de=%b, required rgb=%h hs=%b vs=%b de=%b",
                             e.name, {rc, gc, bc}, hsoc, vsoc, deoc,
                             e.exp_c[14:3], e.exp_c[2], e.exp_c[1], e.exp_c[0]);
                end
            end
        end
    end

    // A reset edge wipes out everything still in the pipe, so pending entries are replaced by idle.
    task automatic issue(input string nm, input logic [14:0] em, input logic [14:0] ec);
        exp_t e;
        e.name = nm;
        if (rst) begin
            while (sb.size() > 0 && sb[sb.size()-1].due >= cyc + 1) void'(sb.pop_back());
            e.exp_m = IDLE;
            e.exp_c = IDLE;
            e.due   = cyc + 1;
        end else begin
            e.exp_m = em;
            e.exp_c = ec;
            e.due   = cyc + 2;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input string nm, input logic [10:0] h, input logic [10:0] v, input logic e,
                         input logic [10:0] hc, input logic [10:0] vc, input logic e_c,
                         input logic hs, input logic vs,
                         input logic [11:0] rgb_m, input logic [11:0] rgb_c);
        @(posedge clk);
        #1;
        rst       = rst_req;
        move_en   = me_req;
        h_count   = h;
        v_count   = v;
        ea        = e;
        h_count_c = hc;
        v_count_c = vc;
        ea_c      = e_c;
        h_synk    = hs;
        v_synk    = vs;
        issue(nm, {rgb_m, hs, vs, e}, {rgb_c, hs, vs, e_c});
    endtask

    task automatic px(input string nm, input int h, input int v, input logic [11:0] rgb);
        drive(nm, 11'(h), 11'(v), 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, rgb, 12'h000);
    endtask

    task automatic pxc(input string nm, input int h, input int v, input logic [11:0] rgb);
        drive(nm, 11'd0, 11'd0, 1'b0, 11'(h), 11'(v), 1'b1, 1'b1, 1'b1, 12'h000, rgb);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            drive("tick_vs_lo", 11'd0, 11'd0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000);
            drive("tick_vs_hi", 11'd0, 11'd0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000);
        end
    endtask

    initial begin
        rst = 1'b1; rst_req = 1'b1; me_req = 1'b1; move_en = 1'b1;
        h_count = 11'd5; v_count = 11'd7; ea = 1'b1; h_synk = 1'b0; v_synk = 1'b0;
        h_count_c = 11'd3; v_count_c = 11'd3; ea_c = 1'b1;

        // reset with arbitrary live inputs, v_synk held low through release
        for (int i = 0; i < 3; i++)
            drive("reset", 11'd5, 11'd7, 1'b1, 11'd3, 11'd3, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
        rst_req = 1'b0;
        drive("release_vs_low", 11'd0, 11'd0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000);

        px("origin_in",   1,  1,  12'hFF0);
        px("origin_far", 63, 63,  12'hFF0);
        px("lat_box",    10, 10,  12'hFF0);
        px("lat_bg_h",   64, 10,  12'h008);
        px("lat_bg_v",   10, 64,  12'h008);
        drive("blank", 11'd10, 11'd10, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000);
        drive("hsync_pulse", 11'd10, 11'd10, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 12'hFF0, 12'h000);

        tick(3);
        px("mv12_left",  11, 12, 12'h008);
        px("mv12_in",    12, 12, 12'hFF0);
        px("mv12_far",   75, 75, 12'hFF0);
        px("mv12_right", 76, 12, 12'h008);
        px("mv12_below", 12, 76, 12'h008);

        me_req = 1'b0;
        tick(1);
        px("hold_in",   12, 12, 12'hFF0);
        px("hold_left", 11, 12, 12'h008);
        me_req = 1'b1;

        tick(13);
        pxc("c64_in",   64, 64, 12'hFF0);
        pxc("c64_left", 63, 64, 12'h008);
        px("m64_in",    64, 64, 12'hFF0);
        tick(1);
        pxc("c66_in",    66,  66, 12'hFF0);
        pxc("c66_left",  65,  66, 12'h008);
        pxc("c66_above", 66,  65, 12'h008);
        pxc("c66_far",  128, 128, 12'hFF0);
        tick(1);
        pxc("c62_in",     62,  62, 12'hFF0);
        pxc("c62_right", 126,  62, 12'h008);
        pxc("c62_left",   61,  62, 12'h008);
        pxc("c62_far",   125, 125, 12'hFF0);

        tick(157);
        px("y700_in",    700, 700, 12'hFF0);
        px("y700_above", 700, 699, 12'h008);
        px("x700_left",  699, 700, 12'h008);
        tick(1);
        px("y704_in",    704, 704, 12'hFF0);
        px("y704_above", 704, 703, 12'h008);
        px("y704_far",   760, 766, 12'hFF0);
        px("y704_below", 710, 768, 12'h008);
        tick(1);
        px("y700b_in",    708, 700, 12'hFF0);
        px("y700b_below", 708, 764, 12'h008);
        px("y700b_last",  708, 763, 12'hFF0);

        tick(62);
        px("x956_in",    956, 452, 12'hFF0);
        px("x956_left",  955, 452, 12'h008);
        px("x956_far",  1019, 515, 12'hFF0);
        px("x956_right",1020, 452, 12'h008);
        tick(1);
        px("x960_in",    960, 448, 12'hFF0);
        px("x960_left",  959, 448, 12'h008);
        px("x960_far",  1022, 511, 12'hFF0);
        tick(1);
        px("x956b_in",   956, 444, 12'hFF0);
        px("x956b_right",1020, 444, 12'h008);
        px("x956b_mid",  960, 444, 12'hFF0);

        px("edge_left",     0, 300, EDGE_RGB);
        px("edge_right", 1023, 300, EDGE_RGB);
        px("edge_top",    500,   0, EDGE_RGB);
        drive("edge_blank", 11'd0, 11'd300, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000);

        px("pre_rst_a", 960, 444, 12'hFF0);
        px("pre_rst_b", 961, 444, 12'hFF0);
        rst_req = 1'b1;
        drive("rst_mid", 11'd962, 11'd444, 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000);
        drive("rst_hold", 11'd963, 11'd444, 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000);
        rst_req = 1'b0;
        px("after_rst_box", 10, 10, 12'hFF0);
        px("after_rst_bg",  64, 64, 12'h008);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never presented, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
